regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32-entry register file. It shares the register file's single write port between the execute-stage and memory-stage write-back requesters using a valid/ready handshake. It registers the winning write onto the register file's write port and tracks destination registers that have an outstanding write, so the issue stage can stall on read-after-write hazards. It sits between the pipeline write-back paths and `RegFile`, and is the only driver of the register file's write port.

---
 rtl/regfile_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the EX/MEM write-backs onto the single RegFile write port and tracks which registers still have a pending write (build option: WB_ARB_ROUND_ROBIN_EN).
// Latency: a transfer drives rf_enable in the next cycle, and a busy bit clears on the same edge that the register file captures the write.
// Backpressure: the losing requester sees ready low until it wins; ready is never high during reset or without its valid.
module regfile_wb_arbiter #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [5:0]        ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    output logic              ex_ready,
    input  logic              mem_valid,
    input  logic [5:0]        mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              iss_set,
    input  logic [5:0]        iss_addr,
    input  logic [5:0]        chk_addr_1,
    input  logic [5:0]        chk_addr_2,
    output logic              busy_1,
    output logic              busy_2,
    output logic [5:0]        rf_write_addr,
    output logic [DATA_W-1:0] rf_input_data,
    output logic              rf_enable,
    output logic              sb_conflict
);

    localparam int IDX_W = $clog2(NREGS);

    logic             grant_ex;
    logic             grant_mem;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Last contended winner; reset to "mem" so the first contention goes to ex.
    logic rr_last_mem;

    always_ff @(posedge clk) begin
        if (rst)
            rr_last_mem <= 1'b1;
        else if (ex_valid && mem_valid)
            rr_last_mem <= grant_mem;
    end
`endif

    always_comb begin
        grant_ex  = 1'b0;
        grant_mem = 1'b0;
        if (!rst) begin
            if (ex_valid && mem_valid) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                if (rr_last_mem)
                    grant_ex = 1'b1;
                else
                    grant_mem = 1'b1;
`else
                grant_mem = 1'b1;
`endif
            end else if (ex_valid) begin
                grant_ex = 1'b1;
            end else if (mem_valid) begin
                grant_mem = 1'b1;
            end
        end
    end

    assign ex_ready  = grant_ex;
    assign mem_ready = grant_mem;

    // Writes to r0 are accepted but dropped: no enable, and addr/data keep their old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_enable     <= 1'b0;
            rf_write_addr <= '0;
            rf_input_data <= '0;
        end else begin
            rf_enable <= 1'b0;
            if (grant_ex && ex_addr != 6'd0) begin
                rf_enable     <= 1'b1;
                rf_write_addr <= ex_addr;
                rf_input_data <= ex_data;
            end else if (grant_mem && mem_addr != 6'd0) begin
                rf_enable     <= 1'b1;
                rf_write_addr <= mem_addr;
                rf_input_data <= mem_data;
            end
        end
    end

    // Bit 0 is never set, so r0 always reads as not busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 1; i < NREGS; i++) begin
            set_mask[i] = iss_set && (int'(iss_addr) == i);
            clr_mask[i] = rf_enable && (int'(rf_write_addr) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            sb_conflict <= 1'b0;
        end else begin
            busy_q      <= (busy_q & ~clr_mask) | set_mask;
            sb_conflict <= |(set_mask & busy_q & ~clr_mask);
        end
    end

    always_comb begin
        busy_1 = 1'b0;
        busy_2 = 1'b0;
        if (int'(chk_addr_1) < NREGS)
            busy_1 = busy_q[chk_addr_1[IDX_W-1:0]];
        if (int'(chk_addr_2) < NREGS)
            busy_2 = busy_q[chk_addr_2[IDX_W-1:0]];
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; register-file writes are checked against an expected-write queue.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid, mem_valid;
    logic [5:0]        ex_addr, mem_addr;
    logic [DATA_W-1:0] ex_data, mem_data;
    logic              ex_ready, mem_ready;
    logic              iss_set;
    logic [5:0]        iss_addr, chk_addr_1, chk_addr_2;
    logic              busy_1, busy_2;
    logic [5:0]        rf_write_addr;
    logic [DATA_W-1:0] rf_input_data;
    logic              rf_enable, sb_conflict;

    int tests = 0;
    int fails = 0;
    logic [5+DATA_W:0] exp_q[$];

    regfile_wb_arbiter #(.NREGS(32), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .iss_set(iss_set), .iss_addr(iss_addr),
        .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
        .busy_1(busy_1), .busy_2(busy_2),
        .rf_write_addr(rf_write_addr), .rf_input_data(rf_input_data),
        .rf_enable(rf_enable), .sb_conflict(sb_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         rf_write_addr, rf_input_data);
            end else begin
                logic [5+DATA_W:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(rf_write_addr), 64'(e[5+DATA_W:DATA_W]));
                check("wr_data", 64'(rf_input_data), 64'(e[DATA_W-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        ex_valid = 1'b1; mem_valid = 1'b1;
        ex_addr = 6'd1; mem_addr = 6'd2;
        ex_data = 32'h11; mem_data = 32'h22;
        iss_set = 1'b0; iss_addr = '0;
        chk_addr_1 = '0; chk_addr_2 = '0;

        // Reset held with both requesters valid
        tick(); tick();
        sample();
        check("rst_ex_ready", 64'(ex_ready), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_rf_enable", 64'(rf_enable), 64'd0);
        check("rst_conflict", 64'(sb_conflict), 64'd0);
        check("rst_wr_addr", 64'(rf_write_addr), 64'd0);
        check("rst_wr_data", 64'(rf_input_data), 64'd0);
        for (int i = 0; i < 32; i++) begin
            chk_addr_1 = 6'(i);
            #1;
            check("rst_busy", 64'(busy_1), 64'd0);
        end
        tick();
        rst = 1'b0; ex_valid = 1'b0; mem_valid = 1'b0;
        tick();

        // Single EX write
        ex_valid = 1'b1; ex_addr = 6'd5; ex_data = 32'hA5;
        sample();
        check("single_ex_ready", 64'(ex_ready), 64'd1);
        check("single_mem_ready", 64'(mem_ready), 64'd0);
        exp_q.push_back({6'd5, 32'hA5});
        tick();
        ex_valid = 1'b0;
        sample();
        check("single_rf_enable", 64'(rf_enable), 64'd1);
        tick();
        sample();
        check("single_en_drop", 64'(rf_enable), 64'd0);
        tick();

        // Contention for 4 cycles
        ex_valid = 1'b1; ex_addr = 6'd3; ex_data = 32'h33;
        mem_valid = 1'b1; mem_addr = 6'd4; mem_data = 32'h44;
        for (int k = 0; k < 4; k++) begin
            logic exp_mem;
`ifdef WB_ARB_ROUND_ROBIN_EN
            exp_mem = (k % 2) == 1;
`else
            exp_mem = 1'b1;
`endif
            sample();
            check("cont_ex_ready", 64'(ex_ready), 64'(!exp_mem));
            check("cont_mem_ready", 64'(mem_ready), 64'(exp_mem));
            if (exp_mem) exp_q.push_back({6'd4, 32'h44});
            else         exp_q.push_back({6'd3, 32'h33});
            tick();
        end
        ex_valid = 1'b0; mem_valid = 1'b0;
        tick();

        // Scoreboard set then clear by a write
        iss_set = 1'b1; iss_addr = 6'd7; chk_addr_1 = 6'd7;
        sample();
        check("sb7_before", 64'(busy_1), 64'd0);
        tick();
        iss_set = 1'b0;
        sample();
        check("sb7_set", 64'(busy_1), 64'd1);
        tick();
        ex_valid = 1'b1; ex_addr = 6'd7; ex_data = 32'h77;
        sample();
        check("sb7_ex_ready", 64'(ex_ready), 64'd1);
        check("sb7_busy_accept", 64'(busy_1), 64'd1);
        exp_q.push_back({6'd7, 32'h77});
        tick();
        ex_valid = 1'b0;
        sample();
        check("sb7_busy_wr_cycle", 64'(busy_1), 64'd1);
        tick();
        sample();
        check("sb7_cleared", 64'(busy_1), 64'd0);
        check("sb7_conflict", 64'(sb_conflict), 64'd0);
        tick();

        // Same-cycle set/clear on r9, then a conflicting re-set
        iss_set = 1'b1; iss_addr = 6'd9; chk_addr_1 = 6'd9;
        tick();
        iss_set = 1'b0;
        ex_valid = 1'b1; ex_addr = 6'd9; ex_data = 32'h99;
        sample();
        check("sb9_busy", 64'(busy_1), 64'd1);
        exp_q.push_back({6'd9, 32'h99});
        tick();
        ex_valid = 1'b0; iss_set = 1'b1;
        sample();
        check("sb9_setclr_en", 64'(rf_enable), 64'd1);
        tick();
        iss_set = 1'b0;
        sample();
        check("sb9_setclr_keep", 64'(busy_1), 64'd1);
        check("sb9_no_conflict", 64'(sb_conflict), 64'd0);
        tick();
        iss_set = 1'b1;
        tick();
        iss_set = 1'b0;
        sample();
        check("sb9_conflict_pulse", 64'(sb_conflict), 64'd1);
        tick();
        sample();
        check("sb9_conflict_end", 64'(sb_conflict), 64'd0);
        check("sb9_still_busy", 64'(busy_1), 64'd1);
        tick();

        // Zero register
        mem_valid = 1'b1; mem_addr = 6'd0; mem_data = 32'hFF;
        sample();
        check("r0_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        mem_valid = 1'b0; iss_set = 1'b1; iss_addr = 6'd0; chk_addr_1 = 6'd0;
        sample();
        check("r0_no_enable", 64'(rf_enable), 64'd0);
        tick();
        iss_set = 1'b0;
        sample();
        check("r0_not_busy", 64'(busy_1), 64'd0);
        tick();

        // Out-of-range addresses are forwarded but not tracked
        iss_set = 1'b1; iss_addr = 6'd40; chk_addr_2 = 6'd40;
        ex_valid = 1'b1; ex_addr = 6'd40; ex_data = 32'h40;
        sample();
        check("oor_ex_ready", 64'(ex_ready), 64'd1);
        exp_q.push_back({6'd40, 32'h40});
        tick();
        iss_set = 1'b0; ex_valid = 1'b0;
        sample();
        check("oor_busy", 64'(busy_2), 64'd0);
        check("oor_conflict", 64'(sb_conflict), 64'd0);
        tick();

        // Reset mid-operation
        iss_set = 1'b1; iss_addr = 6'd20; chk_addr_1 = 6'd20;
        tick();
        iss_set = 1'b0;
        ex_valid = 1'b1; ex_addr = 6'd12; ex_data = 32'hC;
        sample();
        check("mid_busy_set", 64'(busy_1), 64'd1);
        check("mid_ex_ready", 64'(ex_ready), 64'd1);
        exp_q.push_back({6'd12, 32'hC});
        tick();
        rst = 1'b1;
        sample();
        check("mid_rst_ex_ready", 64'(ex_ready), 64'd0);
        tick();
        rst = 1'b0; ex_valid = 1'b0;
        sample();
        check("mid_rst_enable", 64'(rf_enable), 64'd0);
        check("mid_rst_busy", 64'(busy_1), 64'd0);
        tick();
        tick();

        check("drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
